// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM state encoding and default bus widths
// shared by the access controller, its bus interface and the bench.
package mem_ctrl_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: memory-side request/acknowledge bus
// between the access controller (master) and the memory (slave).
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts ACCESS cycles, flags the last allowed one
// so the controller can abort an unacknowledged access.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // high during the TIMEOUT-th cycle so the abort lands on its edge
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding memory access FSM (IDLE/ACCESS/DONE).
// Define MEM_TIMEOUT_EN to abort unacknowledged accesses after TIMEOUT cycles.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [AW-1:0] ar_addr,
  input  logic          req,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  mem_access_ctrl_if.master mem
);

  state_e        state;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          expired;

  // busy is exactly the ACCESS state, so it gates the bus outputs
  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy & we_q;
  assign mem.mem_addr  = busy ? addr_q  : '0;
  assign mem.mem_wdata = busy ? wdata_q : '0;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (state == IDLE && req),
    .en      (state == ACCESS),
    .expired (expired)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT > 0);
  assign expired    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
`ifdef MEM_TIMEOUT_EN
      err     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (req) begin
            addr_q  <= ar_addr;
            we_q    <= we;
            wdata_q <= wdata;
            busy    <= 1'b1;
            state   <= ACCESS;
`ifdef MEM_TIMEOUT_EN
            err     <= 1'b0;
`endif
          end
        end
        ACCESS: begin
          // ack has priority over a same-cycle timeout
          if (mem.mem_ack) begin
            if (!we_q) rdata <= mem.mem_rdata;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (expired) begin
`ifdef MEM_TIMEOUT_EN
            err   <= 1'b1;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl;
// expected rdata/err pushed at request time, popped on each done pulse.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic [AW-1:0] ar_addr = '0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;

  mem_access_ctrl_if #(.AW(AW), .DW(DW)) mem ();

  mem_access_ctrl #(
    .AW(AW), .DW(DW), .TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .ar_addr (ar_addr),
    .req     (req),
    .we      (we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .mem     (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_run = 0;
  int            n_fail = 0;
  int            n_done = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_b && done) begin
      exp_t e;
      n_done++;
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_rdata", rdata, e.rdata);
        chk("sb_err", err, e.err);
      end
    end
  end

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_mreq"}, mem.mem_req, 0);
    chk({tag, "_mwe"}, mem.mem_we, 0);
    chk({tag, "_maddr"}, mem.mem_addr, 0);
    chk({tag, "_mwdata"}, mem.mem_wdata, 0);
  endtask

  task automatic access(input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int waits, input bit poke);
    exp_t e;
    @(negedge clk);
    ar_addr = a;
    we      = w;
    wdata   = wd;
    req     = 1'b1;
    if (!w) model_rdata = rd;
    e.rdata = model_rdata;
    e.err   = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    req = poke;
    if (poke) begin
      ar_addr = 16'h0002;
      we      = ~w;
      wdata   = ~wd;
    end
    chk("err_clr", err, 0);
    for (int i = 0; i <= waits; i++) begin
      chk("busy", busy, 1);
      chk("mreq", mem.mem_req, 1);
      chk("maddr", mem.mem_addr, a);
      chk("mwe", mem.mem_we, w);
      if (w) chk("mwdata", mem.mem_wdata, wd);
      if (i == waits) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = rd;
      end
      @(negedge clk);
      req = 1'b0;
    end
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 16'hDEAD;
    chk("done_hi", done, 1);
    chk("done_busy", busy, 0);
    chk_bus_idle("done");
    @(negedge clk);
    chk("done_lo", done, 0);
    chk("idle_busy", busy, 0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic access_tmo(input logic [AW-1:0] a);
    exp_t e;
    @(negedge clk);
    ar_addr = a;
    we      = 1'b0;
    req     = 1'b1;
    e.rdata = model_rdata;
    e.err   = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      req = 1'b0;
      chk("tmo_busy", busy, 1);
      chk("tmo_done_lo", done, 0);
    end
    @(negedge clk);
    chk("tmo_done", done, 1);
    chk("tmo_err", err, 1);
    @(negedge clk);
    chk("tmo_sticky", err, 1);
  endtask
`endif

  int d0;

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk_bus_idle("rst");
    rst_b = 1'b0;

    access(16'h0040, 1'b0, 16'h0000, 16'hBEEF, 0, 1'b0);
    access(16'h1234, 1'b1, 16'hA5A5, 16'h0F0F, 3, 1'b0);

    @(negedge clk); #1;
    d0 = n_done;
    access(16'h0100, 1'b0, 16'h0000, 16'h1111, 2, 1'b1);
    #1;
    chk("poke_one_done", n_done - d0, 1);
    @(negedge clk);
    chk("poke_no_second", busy, 0);

    d0 = n_done;
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("idle_ack_rdata", rdata, model_rdata);
    chk("idle_ack_done", n_done - d0, 0);

`ifdef MEM_TIMEOUT_EN
    access_tmo(16'h0050);
    access(16'h0051, 1'b0, 16'h0000, 16'h3C3C, 1, 1'b0);
    access(16'h0052, 1'b0, 16'h0000, 16'h5A5A, TMO - 1, 1'b0);
    chk("coll_err", err, 0);
`else
    access(16'h0060, 1'b0, 16'h0000, 16'h2222, 20, 1'b0);
    chk("long_err", err, 0);
`endif

    @(negedge clk); #1;
    d0 = n_done;
    @(negedge clk);
    ar_addr = 16'h0300;
    we      = 1'b0;
    req     = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_b = 1'b1;
    model_rdata = '0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", err, 0);
    chk_bus_idle("mid_rst");
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_no_done", n_done - d0, 0);
    chk("post_rst_busy", busy, 0);

    access(16'h0041, 1'b0, 16'h0000, 16'h7777, 1, 1'b0);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter AW, 16, address width.
REQ-002 Parameter DW, 16, data width.
REQ-003 Parameter TIMEOUT, 15, number of ACCESS-state cycles without mem_ack before the access aborts; used only with MEM_TIMEOUT_EN.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_b  input  1  reset; asynchronous and active-high.
REQ-006 Port ar_addr  input  AW  access address, driven from the address register output.
REQ-007 Port req  input  1  access request from the control unit.
REQ-008 Port we  input  1  1 selects write, 0 selects read; sampled with req.
REQ-009 Port wdata  input  DW  write data; sampled with req.
REQ-010 Port busy  output  1  high while an access is in progress.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port rdata  output  DW  last successfully read word.
REQ-013 Port err  output  1  sticky timeout flag.
REQ-014 Port mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-015 Port mem_addr  output  AW  memory address.
REQ-016 Port mem_wdata  output  DW  memory write data.
REQ-017 Port mem_ack  input  1  memory acknowledge.
REQ-018 Port mem_rdata  input  DW  memory read data, valid when mem_ack=1.

Function
REQ-019 FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-020 IDLE: req=1 at an edge SHALL capture ar_addr, we and wdata into internal registers, clear err, and move to ACCESS.
REQ-021 ACCESS: busy=1 and mem_req=1; mem_addr, mem_we and mem_wdata SHALL come from the captured registers and stay stable until mem_ack.
REQ-022 ACCESS with mem_ack=1 at an edge: on a read, latch mem_rdata into rdata; in all cases move to DONE.
REQ-023 DONE: done=1 and busy=0 for exactly one cycle, then unconditionally return to IDLE.
REQ-024 Minimum latency: req sampled at edge N, mem_req high during cycle N+1, done high during cycle N+2 when mem_ack arrives in cycle N+1.
REQ-025 req is ignored in ACCESS and DONE; requests are not queued.
REQ-026 mem_ack is ignored outside ACCESS.
REQ-027 rdata SHALL change only on a successful read; writes and timeouts leave it unchanged.
REQ-028 mem_req, mem_we, mem_addr and mem_wdata SHALL be 0 outside ACCESS.

Reset
REQ-029 rst_b=1 SHALL asynchronously force state IDLE, the timeout counter to 0, the captured registers to 0, and all outputs to 0, including rdata and err.
REQ-030 Reset asserted mid-ACCESS SHALL abort the access: mem_req drops immediately and no done pulse is generated.

Configuration
REQ-031 With `MEM_TIMEOUT_EN` defined, a counter SHALL count ACCESS cycles; when it reaches TIMEOUT with no mem_ack, set err=1, leave rdata unchanged, and go to DONE (done still pulses).
REQ-032 With `MEM_TIMEOUT_EN` defined, mem_ack and the timeout in the same cycle: mem_ack wins and err stays 0.
REQ-033 With `MEM_TIMEOUT_EN` defined, the counter clears when ACCESS is entered.
REQ-034 Without `MEM_TIMEOUT_EN`, ACCESS waits indefinitely for mem_ack, err is tied to 0, and no counter is synthesized.

Structure
REQ-035 Shared package mem_ctrl_pkg SHALL hold the state encoding constants (IDLE=0, ACCESS=1, DONE=2) and the AW and DW defaults.
REQ-036 The timeout counter SHALL be a sub-module, mem_timeout_cnt (inputs clr and en; output expired), instantiated only under `MEM_TIMEOUT_EN`.

Verification
REQ-037 Read: ar_addr=0x0040, we=0, req pulse; mem_ack=1 with mem_rdata=0xBEEF on the first ACCESS cycle -> mem_addr=0x0040, rdata=0xBEEF, done pulse 2 cycles after req.
REQ-038 Write: ar_addr=0x1234, wdata=0xA5A5, we=1; mem_ack after 3 wait cycles -> mem_we=1, mem_wdata=0xA5A5 stable for 4 cycles, rdata unchanged.
REQ-039 Timeout (MEM_TIMEOUT_EN, TIMEOUT=15): read with mem_ack held 0 -> after 15 ACCESS cycles err=1 and one done pulse; the next req clears err.
REQ-040 Collision: mem_ack arrives in the exact cycle the timeout expires -> err=0 and rdata updated.
REQ-041 Request while busy: second req with ar_addr=0x0002 during ACCESS -> ignored, exactly one done pulse, mem_addr keeps its first value.
REQ-042 Reset mid-access: rst_b=1 in the second ACCESS cycle -> mem_req=0 immediately, all outputs 0, no done pulse; after release the FSM is in IDLE.
